// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared, registered ALU.
// One operation is in flight at a time. Divide-by-zero requests
// (op 3 with b == 0) never reach the ALU. They are answered directly
// with an error response and counted in a saturating counter.
module alu_arbiter #(
    parameter int WIDTH = 72,
    parameter int OPW   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [OPW-1:0]   req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OPW-1:0]   req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic [OPW-1:0]   alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_c,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_data,
    output logic             resp_err,
    output logic             busy,
    output logic [7:0]       dz_count
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] CAPT = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    localparam logic [OPW-1:0] OP_DIV = OPW'(3);

    logic [1:0]       state_reg;
    logic [1:0]       state_next;
    logic             last_grant_reg;
    logic             grant_idx;
    logic             in_idle;
    logic             any_valid;
    logic             accept;
    logic             is_dz;
    logic [OPW-1:0]   sel_op;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;

    assign in_idle    = (state_reg == IDLE);
    assign any_valid  = |req_valid;
    assign busy       = ~in_idle;
    assign resp_valid = (state_reg == RESP);

    // Round-robin choice: on a tie the requester not granted last wins.
    always_comb begin
        grant_idx = 1'b0;
        if (req_valid == 2'b11) begin
            grant_idx = ~last_grant_reg;
        end else if (req_valid[1]) begin
            grant_idx = 1'b1;
        end
    end

    // req_ready is one-hot to the winner, only in IDLE and never during reset.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ready
            assign req_ready[gi] = rst_n & in_idle & any_valid & (grant_idx == 1'(gi));
        end
    endgenerate

    assign accept = |(req_valid & req_ready);

    // Fields of the winning request.
    always_comb begin
        sel_op = req0_op;
        sel_a  = req0_a;
        sel_b  = req0_b;
        if (grant_idx) begin
            sel_op = req1_op;
            sel_a  = req1_a;
            sel_b  = req1_b;
        end
    end

    assign is_dz = (sel_op == OP_DIV) && (sel_b == '0);

    // Next-state logic. A divide-by-zero request skips the ALU and goes to RESP.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (accept) state_next = is_dz ? RESP : EXEC;
            EXEC: state_next = CAPT;
            CAPT: state_next = RESP;
            RESP: if (resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register and round-robin history. The history changes only on acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                last_grant_reg <= grant_idx;
            end
        end
    end

    // ALU operand registers and response payload.
    // ALU operands are left untouched by a divide-by-zero request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_op    <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            resp_id   <= 1'b0;
            resp_data <= '0;
            resp_err  <= 1'b0;
        end else begin
            if (accept) begin
                resp_id <= grant_idx;
                if (is_dz) begin
                    resp_data <= '0;
                    resp_err  <= 1'b1;
                end else begin
                    alu_op <= sel_op;
                    alu_a  <= sel_a;
                    alu_b  <= sel_b;
                end
            end
            if (state_reg == CAPT) begin
                resp_data <= alu_c;
                resp_err  <= 1'b0;
            end
        end
    end

    // Saturating count of divide-by-zero requests that were accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dz_count <= 8'd0;
        end else if (accept && is_dz && (dz_count != 8'hFF)) begin
            dz_count <= dz_count + 8'd1;
        end
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: WIDTH, 72, operand/result width in bits.
REQ-002 Parameter: OPW, 4, ALU opcode width in bits.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 req_valid  in  2  per-requester request valid; bit i is requester i.
REQ-006 req_ready  out  2  per-requester accept; a request is accepted when req_valid[i] and req_ready[i] are both high at a rising edge.
REQ-007 req0_op / req1_op  in  OPW  requested ALU opcode (0..15, same encoding as the ALU).
REQ-008 req0_a, req0_b / req1_a, req1_b  in  WIDTH  requested operands.
REQ-009 alu_op  out  OPW  registered opcode driven to the shared ALU.
REQ-010 alu_a, alu_b  out  WIDTH  registered operands driven to the shared ALU.
REQ-011 alu_c  in  WIDTH  ALU result; the ALU registers it one edge after sampling its inputs.
REQ-012 resp_valid  out  1  response valid; held until accepted.
REQ-013 resp_ready  in  1  response accept.
REQ-014 resp_id  out  1  index of the requester that owns the response.
REQ-015 resp_data  out  WIDTH  result.
REQ-016 resp_err  out  1  divide-by-zero flag for this response.
REQ-017 busy  out  1  high whenever the state is not IDLE.
REQ-018 dz_count  out  8  saturating count of divide-by-zero requests.

Function
REQ-019 The FSM SHALL have four states: IDLE, EXEC, CAPT and RESP.
REQ-020 In IDLE, req_ready SHALL be one-hot to the granted requester whenever any req_valid bit is high, and SHALL be 0 in all other states.
REQ-021 Arbitration SHALL be round-robin: on a tie, grant the requester not granted last; a single valid requester is always granted.
REQ-022 last_grant SHALL update only on acceptance.
REQ-023 On acceptance, alu_op, alu_a and alu_b SHALL load the granted request's fields, and resp_id SHALL load the grant index.
REQ-024 On acceptance of a normal request, the next state SHALL be EXEC.
REQ-025 A request with op==3 and b==0 SHALL NOT be issued to the ALU: alu_* SHALL keep their previous values, the FSM SHALL go directly to RESP with resp_data=0 and resp_err=1, and dz_count SHALL increment, saturating at 255.
REQ-026 In EXEC the ALU samples alu_*; the FSM SHALL go unconditionally to CAPT.
REQ-027 In CAPT, resp_data SHALL load alu_c and resp_err SHALL load 0; the next state SHALL be RESP.
REQ-028 In RESP, resp_valid SHALL be 1; when resp_ready is 1 the FSM SHALL return to IDLE, otherwise it SHALL stay in RESP with resp_data, resp_id and resp_err stable.
REQ-029 Latency for a normal request: acceptance at edge T gives resp_valid high from edge T+3.
REQ-030 Latency for a divide-by-zero request: acceptance at edge T gives resp_valid high from edge T+1.
REQ-031 No new request SHALL be accepted before the current response is accepted, so at most one operation is in flight.
REQ-032 The block SHALL treat op and operands as opaque and SHALL apply no width conversion; resp_data SHALL be exactly WIDTH bits of alu_c.
REQ-033 A request whose req_valid drops before it is accepted SHALL be ignored without side effects.

Reset
REQ-034 While rst_n==0, the block SHALL immediately set: state=IDLE, last_grant=1 (so requester 0 wins the first tie), alu_op=0, alu_a=0, alu_b=0, resp_valid=0, resp_id=0, resp_data=0, resp_err=0, dz_count=0, busy=0 and req_ready=0.
REQ-035 Reset asserted mid-operation SHALL discard the in-flight operation, and no response SHALL be produced for it.

Verification
REQ-036 Requester 0 only, op=0, a=5, b=7, resp_ready=1 -> resp_valid at T+3, resp_data=12, resp_id=0, resp_err=0.
REQ-037 Both requesters valid continuously from reset, op=1 -> grants alternate 0,1,0,1, and each response's resp_id matches its grant.
REQ-038 Requester 1, op=3, a=9, b=0 -> resp_valid at T+1, resp_data=0, resp_err=1, alu_* unchanged, dz_count=1.
REQ-039 resp_ready held 0 for 5 cycles in RESP -> resp_valid, resp_data and resp_id stable, req_ready=0 throughout; a response accepted on the 6th cycle returns the FSM to IDLE.
REQ-040 rst_n pulsed low while in EXEC -> all outputs at reset values, no response follows, and the next request completes normally.
REQ-041 Apply 256 divide-by-zero requests -> dz_count=255 and does not wrap.
